// File: rtl/skinny_inv_shiftrows_deser.sv
// Cell-serial collector for one Skinny state (cell 15 first); applies inverse ShiftRows into a registered valid/ready output.
// Define SKINNY_INV_SR_DOUBLE_BUF_EN to add a second collect buffer so filling overlaps the held output.
module skinny_inv_shiftrows_deser #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_cell,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*W-1:0] out_state,
    output logic            busy
);

    localparam int SW = 16 * W;

`ifdef SKINNY_INV_SR_DOUBLE_BUF_EN
    localparam int COL_LO = 0;
`else
    localparam int COL_LO = W;
`endif

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SW-1:COL_LO] col_q, col_d;
    logic [SW-1:0]    out_q, out_d;
    logic             accept;
    logic             last;
    logic             pop;
    logic [SW-1:0]    assembled;

    function automatic logic [SW-1:0] inv_shift_rows(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r[SW-1 -: 4*W] = s[SW-1 -: 4*W];
        r[11*W +: W]   = s[10*W +: W];
        r[10*W +: W]   = s[9*W +: W];
        r[9*W +: W]    = s[8*W +: W];
        r[8*W +: W]    = s[11*W +: W];
        r[7*W +: W]    = s[5*W +: W];
        r[6*W +: W]    = s[4*W +: W];
        r[5*W +: W]    = s[7*W +: W];
        r[4*W +: W]    = s[6*W +: W];
        r[3*W +: W]    = s[0*W +: W];
        r[2*W +: W]    = s[3*W +: W];
        r[1*W +: W]    = s[2*W +: W];
        r[0*W +: W]    = s[1*W +: W];
        return r;
    endfunction

    // Cell 0 is the final accept, so it bypasses the collect register straight into the permutation.
    assign assembled = {col_q[SW-1:W], in_cell};
    assign out_valid = (state_q == HOLD);
    assign out_state = out_q;
    assign accept    = in_valid & in_ready;
    assign last      = accept & (cnt_q == 4'd15);
    assign pop       = out_valid & out_ready;

`ifdef SKINNY_INV_SR_DOUBLE_BUF_EN
    logic full_q, full_d;

    assign in_ready = ~full_q;
    assign busy     = (cnt_q != 4'd0) | out_valid | full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        out_d   = out_q;
        full_d  = full_q;
        if (clear) begin
            state_d = FILL;
            cnt_d   = 4'd0;
            full_d  = 1'b0;
        end else begin
            if (accept) begin
                for (int k = 1; k < 16; k++) begin
                    if (cnt_q == 4'(15 - k)) col_d[k*W +: W] = in_cell;
                end
                if (cnt_q == 4'd15) col_d[W-1:0] = in_cell;
                cnt_d = cnt_q + 4'd1;
            end
            // A parked full buffer always drains first; in_ready is low while it is parked.
            if (full_q && (state_q == FILL || pop)) begin
                out_d   = inv_shift_rows(col_q);
                full_d  = 1'b0;
                state_d = HOLD;
            end else if (last && (state_q == FILL || pop)) begin
                out_d   = inv_shift_rows(assembled);
                state_d = HOLD;
            end else if (last) begin
                full_d  = 1'b1;
            end else if (pop) begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full_q <= 1'b0;
        else        full_q <= full_d;
    end
`else
    assign in_ready = (state_q == FILL);
    assign busy     = (cnt_q != 4'd0) | out_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        out_d   = out_q;
        if (clear) begin
            state_d = FILL;
            cnt_d   = 4'd0;
        end else begin
            if (accept) begin
                for (int k = 1; k < 16; k++) begin
                    if (cnt_q == 4'(15 - k)) col_d[k*W +: W] = in_cell;
                end
                cnt_d = cnt_q + 4'd1;
            end
            if (last) begin
                out_d   = inv_shift_rows(assembled);
                state_d = HOLD;
            end else if (pop) begin
                state_d = FILL;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= 4'd0;
            col_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            out_q   <= out_d;
        end
    end

endmodule
